// File: rtl/xmem_seq_pkg.sv
// Shared types and constants for the xmem burst sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xmem_seq_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 11;
   localparam int DEPTH      = 2048;
   localparam int LEN_W      = 12;
   localparam int SKID_DEPTH = 2;
   localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

   // SRAM pin encodings (active low)
   localparam logic CEN_ON  = 1'b0;
   localparam logic CEN_OFF = 1'b1;
   localparam logic WEN_WR  = 1'b0;
   localparam logic WEN_RD  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Address increment with wrap at the top of the SRAM.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
   endfunction

endpackage

// File: rtl/xmem_seq_if.sv
// Command, host-write, L0-read and SRAM pin bundle for the xmem sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd/wr/rd use valid-ready; SRAM pins are free-running.
interface xmem_seq_if;
   import xmem_seq_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_base;
   logic [LEN_W-1:0]  cmd_len;

   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;

   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;

   logic              busy;
   logic              done;

   logic              mem_cen;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_d;
   logic [DATA_W-1:0] mem_q;

   // Sequencer side
   modport slave (
      input  cmd_valid, cmd_wr, cmd_base, cmd_len, wr_data, wr_valid, rd_ready, mem_q,
      output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
      output mem_cen, mem_wen, mem_a, mem_d
   );

   // Host / L0 / SRAM side
   modport master (
      output cmd_valid, cmd_wr, cmd_base, cmd_len, wr_data, wr_valid, rd_ready, mem_q,
      input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
      input  mem_cen, mem_wen, mem_a, mem_d
   );

endinterface

// File: rtl/xmem_rd_skid.sv
// Two-entry read skid FIFO with fall-through when empty.
// Latency: 0 cycles when empty (push visible at head same cycle), else head of queue.
// Backpressure: none internally; caller must not push into a full buffer without a pop.
module xmem_rd_skid
   import xmem_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_dat,
   input  logic              pop,
   output logic              head_vld,
   output logic [DATA_W-1:0] head_dat,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [SKID_DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic              store;
   logic              take;

   // An empty buffer forwards the incoming word straight to the head.
   assign head_vld = (count != '0) || push;
   assign head_dat = (count != '0) ? mem[rd_ptr] : push_dat;

   // A word popped straight through the bypass is never stored.
   assign take  = pop && (count != '0);
   assign store = push && !(pop && (count == '0));

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (store) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ~wr_ptr;
         end
         if (take) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + CNT_W'(store) - CNT_W'(take);
      end
   end

endmodule

// File: rtl/xmem_seq.sv
// Burst sequencer driving the 2048x32 xmem SRAM pins for host writes and L0 reads.
// Latency: write word hits SRAM same cycle; first read word at rd_data 2 cycles after accept.
// Backpressure: wr_valid gates writes; reads stall when skid + in-flight credit (2) is used.
module xmem_seq
   import xmem_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   xmem_seq_if.slave   bus
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [LEN_W-1:0]  rem, rem_nxt;
   logic              done_q, done_nxt;
   logic              inflight;
   logic              issue;

   logic              cmd_ready;
   logic              wr_ready;
   logic              mem_cen;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_a;
   logic [DATA_W-1:0] mem_d;

   logic              head_vld;
   logic [DATA_W-1:0] head_dat;
   logic [CNT_W-1:0]  skid_count;
   logic              rd_valid;
   logic              pop;
   logic [2:0]        occ_after;
   logic              last_pop;

   // Read return path: the word requested last cycle lands in the skid buffer.
   xmem_rd_skid u_skid (
      .clk      (clk),
      .reset    (reset),
      .push     (inflight),
      .push_dat (bus.mem_q),
      .pop      (pop),
      .head_vld (head_vld),
      .head_dat (head_dat),
      .count    (skid_count)
   );

   assign rd_valid = !reset && head_vld;
   assign pop      = rd_valid && bus.rd_ready;

   // Words that will be held or still in flight after this cycle's pop.
   assign occ_after = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
   assign last_pop  = pop && (({1'b0, skid_count} + {2'b00, inflight}) == 3'd1);

   // Next-state, counter updates and SRAM pin drive.
   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      rem_nxt   = rem;
      done_nxt  = 1'b0;
      issue     = 1'b0;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      mem_cen   = CEN_OFF;
      mem_wen   = WEN_RD;
      mem_a     = '0;
      mem_d     = '0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               cmd_ready = 1'b1;
               if (bus.cmd_valid) begin
                  addr_nxt = bus.cmd_base;
                  rem_nxt  = bus.cmd_len;
                  if (bus.cmd_len == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     state_nxt = bus.cmd_wr ? ST_WRITE : ST_READ;
                  end
               end
            end
            ST_WRITE: begin
               wr_ready = 1'b1;
               if (bus.wr_valid) begin
                  mem_cen  = CEN_ON;
                  mem_wen  = WEN_WR;
                  mem_a    = addr;
                  mem_d    = bus.wr_data;
                  addr_nxt = next_addr(addr);
                  rem_nxt  = rem - 1'b1;
                  if (rem == LEN_W'(1)) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (occ_after < 3'(SKID_DEPTH)) begin
                  issue    = 1'b1;
                  mem_cen  = CEN_ON;
                  mem_wen  = WEN_RD;
                  mem_a    = addr;
                  addr_nxt = next_addr(addr);
                  rem_nxt  = rem - 1'b1;
                  if (rem == LEN_W'(1)) begin
                     state_nxt = ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (last_pop) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, counters and the registered done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         addr     <= '0;
         rem      <= '0;
         done_q   <= 1'b0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         addr     <= addr_nxt;
         rem      <= rem_nxt;
         done_q   <= done_nxt;
         inflight <= issue;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.wr_ready  = wr_ready;
   assign bus.rd_valid  = rd_valid;
   assign bus.rd_data   = head_dat;
   assign bus.busy      = !reset && (state != ST_IDLE);
   assign bus.done      = !reset && done_q;
   assign bus.mem_cen   = mem_cen;
   assign bus.mem_wen   = mem_wen;
   assign bus.mem_a     = mem_a;
   assign bus.mem_d     = mem_d;

endmodule

// File: tb/tb_xmem_seq.sv
// Directed self-checking bench for xmem_seq with a behavioural 1-cycle SRAM.
// Latency: inputs driven at negedge, outputs sampled 1 time unit later.
// Backpressure: rd_ready patterns exercise the read credit limit.
module tb_xmem_seq;
   import xmem_seq_pkg::*;

   logic clk;
   logic reset;
   xmem_seq_if bus();

   xmem_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [DATA_W-1:0] sram [DEPTH];
   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: write on CEN/WEN low, read data appears the next cycle.
   always @(posedge clk) begin
      if (bus.mem_cen == 1'b0) begin
         if (bus.mem_wen == 1'b0) sram[bus.mem_a] <= bus.mem_d;
         else bus.mem_q <= sram[bus.mem_a];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.cmd_valid = 1'b0;
      bus.cmd_wr    = 1'b0;
      bus.cmd_base  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b0;
   endtask

   // Pure stimulus: writes n words seed+i starting at base, no checking.
   task automatic drive_write(input logic [ADDR_W-1:0] base, input int n, input logic [DATA_W-1:0] seed);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_base = base; bus.cmd_len = LEN_W'(n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = seed + DATA_W'(i);
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      bus.cmd_valid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b want=0", bus.cmd_ready); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b want=0", bus.rd_valid); end
      total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL rst_wr_ready got=%b want=0", bus.wr_ready); end
      total++; if (bus.mem_cen !== 1'b1) begin bad++; $display("FAIL rst_mem_cen got=%b want=1", bus.mem_cen); end
      total++; if (bus.mem_wen !== 1'b1) begin bad++; $display("FAIL rst_mem_wen got=%b want=1", bus.mem_wen); end
      total++; if (bus.mem_a !== 11'd0) begin bad++; $display("FAIL rst_mem_a got=%0d want=0", bus.mem_a); end
      total++; if (bus.mem_d !== 32'd0) begin bad++; $display("FAIL rst_mem_d got=%h want=0", bus.mem_d); end
      @(negedge clk);
      reset = 1'b0;
      bus.cmd_valid = 1'b0;
      #1;
      total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cmd_ready got=%b want=1", bus.cmd_ready); end
   endtask

   task automatic test_write();
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_base = 11'd5; bus.cmd_len = 12'd3;
      #1;
      total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_accept cmd_ready got=%b want=1", bus.cmd_ready); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.cmd_len = 12'd0;             // competing command held while busy
         bus.wr_valid = 1'b1; bus.wr_data = 32'hA0A0_0000 + i;
         #1;
         total++; if (bus.mem_cen !== 1'b0 || bus.mem_wen !== 1'b0) begin bad++; $display("FAIL wr_pins[%0d] cen=%b wen=%b want 0/0", i, bus.mem_cen, bus.mem_wen); end
         total++; if (bus.mem_a !== 11'(5 + i)) begin bad++; $display("FAIL wr_addr[%0d] got=%0d want=%0d", i, bus.mem_a, 5 + i); end
         total++; if (bus.mem_d !== 32'hA0A0_0000 + i) begin bad++; $display("FAIL wr_data[%0d] got=%h want=%h", i, bus.mem_d, 32'hA0A0_0000 + i); end
         total++; if (bus.wr_ready !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL wr_hs[%0d] wr_ready=%b cmd_ready=%b done=%b want 1/0/0", i, bus.wr_ready, bus.cmd_ready, bus.done); end
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0;
      #1;
      total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL wr_done done=%b busy=%b want 1/0", bus.done, bus.busy); end
      total++; if (bus.mem_cen !== 1'b1) begin bad++; $display("FAIL wr_after_cen got=%b want=1", bus.mem_cen); end
      @(negedge clk); #1;
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL wr_done_pulse got=%b want=0", bus.done); end
   endtask

   task automatic test_read();
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_base = 11'd5; bus.cmd_len = 12'd3; bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      total++; if (bus.mem_cen !== 1'b0 || bus.mem_wen !== 1'b1 || bus.mem_a !== 11'd5) begin bad++; $display("FAIL rd_issue0 cen=%b wen=%b a=%0d want 0/1/5", bus.mem_cen, bus.mem_wen, bus.mem_a); end
      total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid got=%b want=0", bus.rd_valid); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hA0A0_0000 + i) begin bad++; $display("FAIL rd_word[%0d] valid=%b data=%h want 1/%h", i, bus.rd_valid, bus.rd_data, 32'hA0A0_0000 + i); end
         total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rd_early_done[%0d] got=%b want=0", i, bus.done); end
      end
      @(negedge clk); #1;
      total++; if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rd_done done=%b rd_valid=%b busy=%b want 1/0/0", bus.done, bus.rd_valid, bus.busy); end
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_wrap();
      logic [ADDR_W-1:0] exp_a [4];
      exp_a[0] = 11'd2046; exp_a[1] = 11'd2047; exp_a[2] = 11'd0; exp_a[3] = 11'd1;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_base = 11'd2046; bus.cmd_len = 12'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 32'h5A5A_0000 + i;
         #1;
         total++; if (bus.mem_cen !== 1'b0 || bus.mem_a !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d] cen=%b a=%0d want 0/%0d", i, bus.mem_cen, bus.mem_a, exp_a[i]); end
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b want=1", bus.done); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int issued = 0;
      int got = 0;
      int last_pop_k = -10;
      bit done_seen = 0;
      drive_write(11'd100, 8, 32'hB0B0_0000);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_base = 11'd100; bus.cmd_len = 12'd8; bus.rd_ready = 1'b0;
      for (int k = 1; k <= 80 && !done_seen; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.rd_ready = ((k % 3) == 1);
         #1;
         if (bus.mem_cen == 1'b0) begin
            total++; if (bus.mem_a !== 11'(100 + issued)) begin bad++; $display("FAIL bp_addr[%0d] got=%0d want=%0d", issued, bus.mem_a, 100 + issued); end
            issued++;
         end
         if (bus.rd_valid && bus.rd_ready) begin
            total++; if (bus.rd_data !== 32'hB0B0_0000 + got) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", got, bus.rd_data, 32'hB0B0_0000 + got); end
            got++;
            last_pop_k = k;
         end
         total++; if (issued - got > 2) begin bad++; $display("FAIL bp_outstanding k=%0d got=%0d want<=2", k, issued - got); end
         if (bus.done) begin
            done_seen = 1;
            total++; if (k != last_pop_k + 1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL bp_done_timing k=%0d last_pop=%0d rd_valid=%b want k=last_pop+1, 0", k, last_pop_k, bus.rd_valid); end
         end
      end
      total++; if (!done_seen) begin bad++; $display("FAIL bp_timeout done=0 want=1 within 80 cycles"); end
      total++; if (got != 8 || issued != 8) begin bad++; $display("FAIL bp_counts popped=%0d issued=%0d want 8/8", got, issued); end
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_len0_back_to_back();
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_base = 11'd9; bus.cmd_len = 12'd0;
      #1;
      total++; if (bus.mem_cen !== 1'b1 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL len0_accept cen=%b cmd_ready=%b want 1/1", bus.mem_cen, bus.cmd_ready); end
      @(negedge clk);
      bus.cmd_wr = 1'b0;                  // second zero-length command offered on the done cycle
      #1;
      total++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_cen !== 1'b1) begin bad++; $display("FAIL len0_done done=%b cmd_ready=%b busy=%b cen=%b want 1/1/0/1", bus.done, bus.cmd_ready, bus.busy, bus.mem_cen); end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      total++; if (bus.done !== 1'b1 || bus.mem_cen !== 1'b1) begin bad++; $display("FAIL b2b_done done=%b cen=%b want 1/1", bus.done, bus.mem_cen); end
      @(negedge clk); #1;
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b want=0", bus.done); end
   endtask

   task automatic test_reset_mid();
      drive_write(11'd200, 8, 32'hD0D0_0000);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_base = 11'd200; bus.cmd_len = 12'd8; bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hD0D0_0000 + i) begin bad++; $display("FAIL rm_word[%0d] valid=%b data=%h want 1/%h", i, bus.rd_valid, bus.rd_data, 32'hD0D0_0000 + i); end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (bus.busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.mem_cen !== 1'b1 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rm_after busy=%b rd_valid=%b cen=%b done=%b cmd_ready=%b want 0/0/1/0/1", bus.busy, bus.rd_valid, bus.mem_cen, bus.done, bus.cmd_ready); end
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_base = 11'd200; bus.cmd_len = 12'd2;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      #1;
      total++; if (bus.mem_cen !== 1'b0 || bus.mem_a !== 11'd200 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rm_reissue cen=%b a=%0d rd_valid=%b want 0/200/0", bus.mem_cen, bus.mem_a, bus.rd_valid); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hD0D0_0000 + i) begin bad++; $display("FAIL rm_rd2[%0d] valid=%b data=%h want 1/%h", i, bus.rd_valid, bus.rd_data, 32'hD0D0_0000 + i); end
      end
      @(negedge clk); #1;
      total++; if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rm_done done=%b rd_valid=%b want 1/0", bus.done, bus.rd_valid); end
      @(negedge clk); #1;
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_done_pulse got=%b want=0", bus.done); end
      bus.rd_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) sram[i] = '0;
      bus.mem_q = '0;
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_backpressure();
      test_len0_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
